// File: rtl/reg_file_mp_if.sv
// Bundle of write, read, reserve and scoreboard signals between the issue/writeback
// pipeline (master) and the multi-port register file (slave).
interface reg_file_mp_if #(
   parameter int XLEN    = 32,
   parameter int NUM_REG = 8,
   parameter int NUM_RP  = 2,
   parameter int NUM_WP  = 2
);
   localparam int AW = $clog2(NUM_REG);

   logic [NUM_WP-1:0]              wr_en_i;
   logic [NUM_WP-1:0][AW-1:0]      wr_addr_i;
   logic [NUM_WP-1:0][XLEN-1:0]    wr_data_i;
   logic [NUM_RP-1:0][AW-1:0]      rd_addr_i;
   logic [NUM_RP-1:0][XLEN-1:0]    rd_data_o;
   logic [NUM_RP-1:0]              rd_hazard_o;
   logic                           resv_en_i;
   logic [AW-1:0]                  resv_addr_i;
   logic [NUM_REG-1:0]             busy_o;
   logic                           wr_conflict_o;

   modport master (
      output wr_en_i, wr_addr_i, wr_data_i, rd_addr_i, resv_en_i, resv_addr_i,
      input  rd_data_o, rd_hazard_o, busy_o, wr_conflict_o
   );

   modport slave (
      input  wr_en_i, wr_addr_i, wr_data_i, rd_addr_i, resv_en_i, resv_addr_i,
      output rd_data_o, rd_hazard_o, busy_o, wr_conflict_o
   );
endinterface

// File: rtl/reg_file_mp.sv
// Multi-port register file: NUM_WP prioritised write ports, NUM_RP combinational read
// ports with optional write bypass, and a busy scoreboard with per-read hazard flags.

module reg_file_mp_rport #(
   parameter int XLEN    = 32,
   parameter int NUM_REG = 8,
   parameter int BYPASS  = 1,
   localparam int AW     = $clog2(NUM_REG)
) (
   input  logic [AW-1:0]                  rd_addr_i,
   input  logic [NUM_REG-1:0][XLEN-1:0]   regs_i,
   input  logic [NUM_REG-1:0]             wr_hit_i,
   input  logic [NUM_REG-1:0][XLEN-1:0]   wr_val_i,
   input  logic [NUM_REG-1:0]             busy_i,
   output logic [XLEN-1:0]                rd_data_o,
   output logic                           rd_hazard_o
);
   logic fwd;

   // wr_hit_i and busy_i are never set for register 0, so it reads 0 and never hazards
   assign fwd         = (BYPASS != 0) && wr_hit_i[rd_addr_i];
   assign rd_data_o   = fwd ? wr_val_i[rd_addr_i] : regs_i[rd_addr_i];
   assign rd_hazard_o = busy_i[rd_addr_i] && !fwd;
endmodule

module reg_file_mp #(
   parameter int XLEN    = 32,
   parameter int NUM_REG = 8,
   parameter int NUM_RP  = 2,
   parameter int NUM_WP  = 2,
   parameter int BYPASS  = 1
) (
   input  logic          clk_i,
   input  logic          srst_ni,
   reg_file_mp_if.slave  bus
);
   localparam int AW = $clog2(NUM_REG);

   logic [NUM_REG-1:0][XLEN-1:0] regs_q, regs_d;
   logic [NUM_REG-1:0]           busy_q, busy_d;
   logic [NUM_REG-1:0]           wr_hit;
   logic [NUM_REG-1:0][XLEN-1:0] wr_val;
   logic                         conflict;
   logic [NUM_RP-1:0][XLEN-1:0]  rd_data;
   logic [NUM_RP-1:0]            rd_haz;

   // Ascending port scan: a later (higher-index) match overrides, giving it priority
   always_comb begin
      wr_hit = '0;
      wr_val = '0;
      for (int r = 1; r < NUM_REG; r++) begin
         for (int w = 0; w < NUM_WP; w++) begin
            if (bus.wr_en_i[w] && bus.wr_addr_i[w] == AW'(r)) begin
               wr_hit[r] = 1'b1;
               wr_val[r] = bus.wr_data_i[w];
            end
         end
      end
   end

   always_comb begin
      regs_d    = regs_q;
      busy_d    = busy_q;
      regs_d[0] = '0;
      busy_d[0] = 1'b0;
      for (int r = 1; r < NUM_REG; r++) begin
         if (wr_hit[r]) regs_d[r] = wr_val[r];
         // Reservation beats writeback: a new producer was issued after the old one
         if (bus.resv_en_i && bus.resv_addr_i == AW'(r)) busy_d[r] = 1'b1;
         else if (wr_hit[r])                              busy_d[r] = 1'b0;
      end
   end

   always_comb begin
      conflict = 1'b0;
      for (int i = 0; i < NUM_WP; i++) begin
         for (int j = i + 1; j < NUM_WP; j++) begin
            if (bus.wr_en_i[i] && bus.wr_en_i[j] &&
                bus.wr_addr_i[i] == bus.wr_addr_i[j] && bus.wr_addr_i[i] != '0)
               conflict = 1'b1;
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (!srst_ni) begin
         regs_q <= '0;
         busy_q <= '0;
      end else begin
         regs_q <= regs_d;
         busy_q <= busy_d;
      end
   end

   for (genvar p = 0; p < NUM_RP; p++) begin : g_rp
      reg_file_mp_rport #(
         .XLEN    (XLEN),
         .NUM_REG (NUM_REG),
         .BYPASS  (BYPASS)
      ) u_rport (
         .rd_addr_i   (bus.rd_addr_i[p]),
         .regs_i      (regs_q),
         .wr_hit_i    (wr_hit),
         .wr_val_i    (wr_val),
         .busy_i      (busy_q),
         .rd_data_o   (rd_data[p]),
         .rd_hazard_o (rd_haz[p])
      );
   end

   assign bus.rd_data_o     = rd_data;
   assign bus.rd_hazard_o   = rd_haz;
   assign bus.busy_o        = busy_q;
   assign bus.wr_conflict_o = conflict;
endmodule

// File: doc/reg_file_mp.md
Name: reg_file_mp

Overview:
- Parametrised multi-port successor of the core register file.
- Provides NUM_WP write ports with fixed priority, NUM_RP combinational read ports, and optional write-to-read bypass.
- Includes a per-register busy scoreboard, set at issue and cleared at writeback, plus per-read-port hazard flags.
- Sits between decode/issue (read and reserve) and writeback (write) in the multi-issue pipeline. Register 0 is hardwired zero.

Parameters:
- XLEN, 32, data width of each register.
- NUM_REG, 8, number of architectural registers (>=2, power of two).
- NUM_RP, 2, number of read ports (>=1).
- NUM_WP, 2, number of write ports (>=1).
- BYPASS, 1, 1 = same-cycle write data forwarded to reads; 0 = reads see registered state only.
- AW, $clog2(NUM_REG), derived address width; not to be overridden.

Ports:
- clk_i  in  1  global clock.
- srst_ni  in  1  synchronous active-low reset.
- wr_en_i  in  NUM_WP  per-port write enable.
- wr_addr_i  in  NUM_WP x AW  per-port destination address.
- wr_data_i  in  NUM_WP x XLEN  per-port write data.
- rd_addr_i  in  NUM_RP x AW  per-port source address.
- rd_data_o  out  NUM_RP x XLEN  per-port read data.
- rd_hazard_o  out  NUM_RP  1 = addressed register busy and not resolved this cycle.
- resv_en_i  in  1  reserve (mark busy) request.
- resv_addr_i  in  AW  register to reserve.
- busy_o  out  NUM_REG  scoreboard vector; bit 0 is always 0.
- wr_conflict_o  out  1  combinational: two or more enabled write ports target the same non-zero address this cycle.

Behaviour:
- Reset: srst_ni sampled low at posedge clk_i clears all registers and all busy bits. Writes and reservations in that cycle are ignored.
  - After the reset edge: rd_data_o=0, rd_hazard_o=0, busy_o=0, and wr_conflict_o reflects inputs only.
  - Reset asserted mid-operation discards all state at that edge; the scoreboard does not survive reset.
- Register 0: reads return 0 and it is never busy. Writes and reservations addressed to 0 are dropped, and address 0 never contributes to wr_conflict_o.
- Write: at posedge with srst_ni=1, each enabled port writes its data. When several enabled ports target the same address, the highest-index port wins. Latency is 1 cycle to the registered state.
- Read: combinational from rd_addr_i.
  - BYPASS=1: when any enabled write port targets the read address (non-zero) in the same cycle, the output is the winning port's wr_data_i.
  - BYPASS=0: the output is registered state.
- Scoreboard (per register r, r>=1, updated at posedge):
  - set when resv_en_i && resv_addr_i==r;
  - cleared when any enabled write port targets r;
  - set and clear together on the same r: set wins (a new producer has been issued after the old writeback);
  - reserving an already busy register leaves it busy, with no error.
- Hazard:
  - BYPASS=1: rd_hazard_o[p] = busy[rd_addr_i[p]] && no enabled write targets rd_addr_i[p] this cycle.
  - BYPASS=0: rd_hazard_o[p] = busy[rd_addr_i[p]].
  - Address 0 never hazards.
- No FSM beyond the state described: the register array plus the busy vector. All outputs are defined every cycle, with no X on the outputs after the first reset.

Test Plan:
- Reset then read all addresses on all ports -> rd_data_o=0, busy_o=0, rd_hazard_o=0; write port 0 to reg 0 with 0xDEADBEEF -> read of reg 0 still 0.
- Same cycle: wr0 reg3=0x11, wr1 reg3=0x22 -> wr_conflict_o=1; next cycle reg3 reads 0x22. wr0 reg3, wr1 reg5 -> no conflict; both stored.
- BYPASS=1: write reg4=0xA5A5A5A5 while rd_addr_i[1]=4 -> same-cycle rd_data_o[1]=0xA5A5A5A5. BYPASS=0 -> old value this cycle, new value next cycle.
- Reserve reg6 -> next cycle busy_o[6]=1 and reading reg6 gives rd_hazard_o=1. Then write reg6=0x7 -> hazard drops in the same cycle (BYPASS=1) and busy_o[6]=0 next cycle.
- Reserve reg2 and write reg2 in the same cycle -> busy_o[2]=1 afterwards and reg2=written data.
- Reserve reg1 and write reg5=0x9, then assert srst_ni=0 for one cycle -> busy_o=0 and reg5 reads 0. A write issued during that reset cycle is not stored.
